ttc_readout_sequencer: RTL and testbench
========================================

Name: ttc_readout_sequencer

Overview:
- Consumes trigger-information words from the TTC trigger FIFO, written by the TTC trigger receiver.
- For each non-empty event, it sequences a DDR3 readout across the channels, one at a time, in ascending index order.
- When all channels finish, it returns the freed burst count to the receiver's DDR3 occupancy accounting (readout_done/readout_size).
- It then forwards a 128-bit event header to the command manager.
- The block sits between the trigger FIFO, the five channel readout engines and the command manager; all are in the 40 MHz TTC clock domain.

Parameters:
- NCHAN, 5, number of channels sequenced.
- TMO_W, 24, width of the per-channel timeout counter.

Ports:
- clk  in  1  40 MHz TTC clock.
- reset  in  1  synchronous, active-high.
- trig_fifo_valid  in  1  FIFO has a word.
- trig_fifo_ready  out  1  pop strobe; a word is consumed on valid&ready.
- trig_fifo_data  in  128  {33'd0, empty[94], type[93:92], evt_cnt[91:68], trig_num[67:44], timestamp[43:0]}.
- chan_en  in  NCHAN  enabled channels; snapshotted when a word is accepted.
- timeout_limit  in  TMO_W  wait limit in cycles; 0 disables the timeout.
- acq_trigger  in  1  receiver trigger pulse, used to avoid collision with readout_done.
- chan_rd_start  out  NCHAN  one-cycle start pulse to one channel.
- chan_rd_done  in  NCHAN  one-cycle completion pulse per channel.
- chan_rd_bursts  in  22  burst count; valid with the active channel's done.
- readout_done  out  1  one-cycle pulse to the receiver.
- readout_size  out  22  freed bursts; valid with readout_done.
- hdr_valid  out  1  header valid.
- hdr_ready  in  1  command manager accepts the header.
- hdr_data  out  128  {11'd0, size[21:0], word[94:0]}.
- state  out  3  current FSM state (binary).
- error_timeout  out  1  sticky; set on timeout.
- error_size_mismatch  out  1  sticky; channels reported unequal burst counts.
- error_unexpected_done  out  1  sticky; done seen from a non-active channel.

Behaviour:
- Reset values: every output is 0; state=IDLE; all sticky flags cleared.
- Reset mid-operation: return to IDLE next cycle. Any in-flight channel readout is abandoned (no readout_done) and the latched word is discarded.
- IDLE: trig_fifo_ready=1. On valid at edge N, latch the word and snapshot chan_en into en_q.
  - empty=1 or en_q==0: go to HEADER with size 0; hdr_valid rises at N+1; no readout_done.
  - Otherwise: idx = lowest set bit of en_q; go to ISSUE.
- ISSUE: chan_rd_start[idx]=1 for exactly one cycle (cycle N+1 for the first channel). Clear the wait counter. Go to WAIT.
- WAIT:
  - On chan_rd_done[idx] at edge M: capture chan_rd_bursts.
  - First channel of the event: size_q = bursts. Later channel with bursts != size_q: set error_size_mismatch; size_q is unchanged.
  - If a higher enabled bit exists in en_q: idx = that bit, go to ISSUE (next start at M+1). Otherwise go to REPORT.
  - Timeout: if timeout_limit != 0 and the counter reaches timeout_limit with no done, set error_timeout and go to ERROR.
- REPORT:
  - If acq_trigger=0: readout_done=1 and readout_size=size_q for one cycle (cycle M+1), then go to HEADER.
  - If acq_trigger=1: stay in REPORT and retry next cycle. readout_done must never coincide with acq_trigger.
- HEADER: hdr_valid=1 and hdr_data stable until hdr_ready. On valid&ready, go to IDLE. trig_fifo_ready stays 0 here, so the next pop is no earlier than the cycle after the handshake.
- ERROR: terminal; only reset exits. No outputs asserted except state and the sticky flags.
- chan_rd_done bits other than the active idx, or any done outside WAIT, are ignored and set error_unexpected_done.
- Counter rules: the wait counter saturates at all-ones. size_q is 22 bits; no arithmetic on it beyond compare.
- chan_en changes mid-event have no effect on that event.

Decomposition:
- Shared package ttc_pkg:
  - FIFO word field bit positions (EMPTY_BIT=94, TYPE_MSB/LSB, EVT_CNT, TRIG_NUM, TIMESTAMP ranges).
  - Header size field [116:95].
  - State encoding: IDLE=0, ISSUE=1, WAIT=2, REPORT=3, HEADER=4, ERROR=5.
- One sub-module: chan_priority_select, a combinational priority encoder.
  - Inputs: en_q and a current index.
  - Outputs: next enabled index above the current one, a found flag, and the lowest enabled index.

Test Plan:
- chan_en=5'b10101, word empty=0, each channel returns 22'd1000 on done 10 cycles after its start:
  - starts on ch0, ch2, ch4 in that order, each one cycle after the previous done;
  - readout_done pulses once with size 1000;
  - hdr_data[116:95]=1000 and hdr_data[94:0] equals the word.
- Word with empty=1: no chan_rd_start; no readout_done; hdr_valid at N+1 with size 0.
- acq_trigger held high for 3 cycles when REPORT is entered: readout_done delayed to the first cycle with acq_trigger=0; exactly one pulse.
- chan_en=5'b00011, ch1 never answers, timeout_limit=100: error_timeout set; state=ERROR; no readout_done; reset returns to IDLE with all flags 0.
- ch0 returns 500 and ch1 returns 400: error_size_mismatch=1; readout_size=500. A done on ch3 during WAIT sets error_unexpected_done.
- hdr_ready held low for 20 cycles with trig_fifo_valid high: hdr_data stable and trig_fifo_ready=0 throughout; the pop occurs only after the header handshake.

Source files
------------

// File: rtl/ttc_pkg.sv
// Shared definitions for the TTC readout sequencer: trigger word field layout,
// event header layout and the sequencer state encoding.
package ttc_pkg;

   localparam int FIFO_W        = 128;
   localparam int HDR_W         = 128;
   localparam int WORD_W        = 95;
   localparam int SIZE_W        = 22;

   localparam int EMPTY_BIT     = 94;
   localparam int TYPE_MSB      = 93;
   localparam int TYPE_LSB      = 92;
   localparam int EVT_CNT_MSB   = 91;
   localparam int EVT_CNT_LSB   = 68;
   localparam int TRIG_NUM_MSB  = 67;
   localparam int TRIG_NUM_LSB  = 44;
   localparam int TIMESTAMP_MSB = 43;
   localparam int TIMESTAMP_LSB = 0;

   localparam int HDR_SIZE_MSB  = 116;
   localparam int HDR_SIZE_LSB  = 95;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      ISSUE  = 3'd1,
      WAIT   = 3'd2,
      REPORT = 3'd3,
      HEADER = 3'd4,
      ERROR  = 3'd5
   } state_t;

   // Header handed to the command manager: freed size above the raw trigger word.
   function automatic logic [HDR_W-1:0] buildHeader(input logic [SIZE_W-1:0] size,
                                                    input logic [WORD_W-1:0] word);
      logic [HDR_W-1:0] hdr;
      hdr = '0;
      hdr[HDR_SIZE_MSB:HDR_SIZE_LSB] = size;
      hdr[WORD_W-1:0] = word;
      return hdr;
   endfunction

endpackage

// File: rtl/ttc_readout_sequencer_if.sv
// Bundle of every sequencer-facing signal: trigger FIFO, channel engines,
// receiver occupancy return, command manager header and status.
interface ttc_readout_sequencer_if #(
   parameter int NCHAN = 5,
   parameter int TMO_W = 24
);
   import ttc_pkg::*;

   logic                trig_fifo_valid;
   logic                trig_fifo_ready;
   logic [FIFO_W-1:0]   trig_fifo_data;
   logic [NCHAN-1:0]    chan_en;
   logic [TMO_W-1:0]    timeout_limit;
   logic                acq_trigger;
   logic [NCHAN-1:0]    chan_rd_start;
   logic [NCHAN-1:0]    chan_rd_done;
   logic [SIZE_W-1:0]   chan_rd_bursts;
   logic                readout_done;
   logic [SIZE_W-1:0]   readout_size;
   logic                hdr_valid;
   logic                hdr_ready;
   logic [HDR_W-1:0]    hdr_data;
   logic [2:0]          state;
   logic                error_timeout;
   logic                error_size_mismatch;
   logic                error_unexpected_done;

   modport master (
      input  trig_fifo_valid, trig_fifo_data, chan_en, timeout_limit, acq_trigger,
             chan_rd_done, chan_rd_bursts, hdr_ready,
      output trig_fifo_ready, chan_rd_start, readout_done, readout_size, hdr_valid,
             hdr_data, state, error_timeout, error_size_mismatch, error_unexpected_done
   );

   modport slave (
      output trig_fifo_valid, trig_fifo_data, chan_en, timeout_limit, acq_trigger,
             chan_rd_done, chan_rd_bursts, hdr_ready,
      input  trig_fifo_ready, chan_rd_start, readout_done, readout_size, hdr_valid,
             hdr_data, state, error_timeout, error_size_mismatch, error_unexpected_done
   );

endinterface

// File: rtl/chan_priority_select.sv
// Combinational priority encoder: lowest enabled channel, and the next enabled
// channel strictly above the current index.
module chan_priority_select #(
   parameter int NCHAN = 5,
   parameter int IDX_W = 3
) (
   input  logic [NCHAN-1:0] en_i,
   input  logic [IDX_W-1:0] cur_i,
   output logic [IDX_W-1:0] next_o,
   output logic             found_o,
   output logic [IDX_W-1:0] low_o
);

   // Scanning downward lets the lowest qualifying bit win both searches.
   always_comb begin
      next_o  = '0;
      found_o = 1'b0;
      low_o   = '0;
      for (int i = NCHAN - 1; i >= 0; i--) begin
         if (en_i[i] && (i > int'(cur_i))) begin
            next_o  = IDX_W'(i);
            found_o = 1'b1;
         end
         if (en_i[i]) begin
            low_o = IDX_W'(i);
         end
      end
   end

endmodule

// File: rtl/ttc_readout_sequencer.sv
// Pops trigger words, reads each enabled channel out in ascending order, returns
// the freed burst count to the receiver and forwards the event header.
module ttc_readout_sequencer
   import ttc_pkg::*;
#(
   parameter int NCHAN = 5,
   parameter int TMO_W = 24
) (
   input  logic                    clk,
   input  logic                    reset,
   ttc_readout_sequencer_if.master bus
);

   localparam int IDX_W = $clog2(NCHAN);

   state_t              state_q;
   logic [WORD_W-1:0]   word_q;
   logic [NCHAN-1:0]    en_q;
   logic [NCHAN-1:0]    start_q;
   logic [IDX_W-1:0]    idx_q;
   logic [SIZE_W-1:0]   size_q;
   logic                first_q;
   logic [TMO_W-1:0]    waitCnt_q;
   logic                ready_q;
   logic                hdrValid_q;
   logic [HDR_W-1:0]    hdrData_q;
   logic                errTimeout_q;
   logic                errMismatch_q;
   logic                errUnexpected_q;

   logic [NCHAN-1:0]    selEn;
   logic [NCHAN-1:0]    activeMask;
   logic [IDX_W-1:0]    nextIdx;
   logic [IDX_W-1:0]    lowIdx;
   logic                nextFound;
   logic                popWord;
   logic                activeDone;
   logic                strayDone;
   logic                reportNow;
   logic                unused_fifoHi;

   // While idle the encoder looks at the live enables so the first channel is
   // known in the same cycle the word is popped and the mask is snapshotted.
   assign selEn      = (state_q == IDLE) ? bus.chan_en : en_q;
   assign popWord    = (state_q == IDLE) && ready_q && bus.trig_fifo_valid;
   assign activeMask = (state_q == WAIT) ? (NCHAN'(1) << idx_q) : '0;
   assign activeDone = |(bus.chan_rd_done & activeMask);
   assign strayDone  = |(bus.chan_rd_done & ~activeMask);
   assign unused_fifoHi = ^bus.trig_fifo_data[FIFO_W-1:WORD_W];

   chan_priority_select #(
      .NCHAN (NCHAN),
      .IDX_W (IDX_W)
   ) u_sel (
      .en_i    (selEn),
      .cur_i   (idx_q),
      .next_o  (nextIdx),
      .found_o (nextFound),
      .low_o   (lowIdx)
   );

   // The occupancy return is gated combinationally by the live trigger pulse so
   // the two can never share a cycle at the receiver.
   assign reportNow = (state_q == REPORT) && !bus.acq_trigger;

   assign bus.trig_fifo_ready       = ready_q;
   assign bus.chan_rd_start         = start_q;
   assign bus.readout_done          = reportNow;
   assign bus.readout_size          = reportNow ? size_q : '0;
   assign bus.hdr_valid             = hdrValid_q;
   assign bus.hdr_data              = hdrData_q;
   assign bus.state                 = state_q;
   assign bus.error_timeout         = errTimeout_q;
   assign bus.error_size_mismatch   = errMismatch_q;
   assign bus.error_unexpected_done = errUnexpected_q;

   // Sequencer state, registered outputs and sticky error flags.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q         <= IDLE;
         word_q          <= '0;
         en_q            <= '0;
         start_q         <= '0;
         idx_q           <= '0;
         size_q          <= '0;
         first_q         <= 1'b0;
         waitCnt_q       <= '0;
         ready_q         <= 1'b0;
         hdrValid_q      <= 1'b0;
         hdrData_q       <= '0;
         errTimeout_q    <= 1'b0;
         errMismatch_q   <= 1'b0;
         errUnexpected_q <= 1'b0;
      end else begin
         start_q <= '0;
         if (strayDone) begin
            errUnexpected_q <= 1'b1;
         end
         case (state_q)
            IDLE: begin
               if (popWord) begin
                  ready_q <= 1'b0;
                  word_q  <= bus.trig_fifo_data[WORD_W-1:0];
                  en_q    <= bus.chan_en;
                  size_q  <= '0;
                  first_q <= 1'b1;
                  if (bus.trig_fifo_data[EMPTY_BIT] || (bus.chan_en == '0)) begin
                     hdrValid_q <= 1'b1;
                     hdrData_q  <= buildHeader('0, bus.trig_fifo_data[WORD_W-1:0]);
                     state_q    <= HEADER;
                  end else begin
                     idx_q   <= lowIdx;
                     start_q <= NCHAN'(1) << lowIdx;
                     state_q <= ISSUE;
                  end
               end else begin
                  ready_q <= 1'b1;
               end
            end
            ISSUE: begin
               waitCnt_q <= '0;
               state_q   <= WAIT;
            end
            WAIT: begin
               if (activeDone) begin
                  first_q <= 1'b0;
                  if (first_q) begin
                     size_q <= bus.chan_rd_bursts;
                  end else if (bus.chan_rd_bursts != size_q) begin
                     errMismatch_q <= 1'b1;
                  end
                  if (nextFound) begin
                     idx_q   <= nextIdx;
                     start_q <= NCHAN'(1) << nextIdx;
                     state_q <= ISSUE;
                  end else begin
                     state_q <= REPORT;
                  end
               end else if ((bus.timeout_limit != '0) && (waitCnt_q == bus.timeout_limit)) begin
                  errTimeout_q <= 1'b1;
                  state_q      <= ERROR;
               end else if (waitCnt_q != '1) begin
                  waitCnt_q <= waitCnt_q + TMO_W'(1);
               end
            end
            REPORT: begin
               if (!bus.acq_trigger) begin
                  hdrValid_q <= 1'b1;
                  hdrData_q  <= buildHeader(size_q, word_q);
                  state_q    <= HEADER;
               end
            end
            HEADER: begin
               if (bus.hdr_ready) begin
                  hdrValid_q <= 1'b0;
                  ready_q    <= 1'b1;
                  state_q    <= IDLE;
               end
            end
            default: begin
               state_q <= ERROR;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ttc_readout_sequencer.sv
// Directed bench for ttc_readout_sequencer: a small channel-engine model answers
// start pulses, and each scenario task checks its own hand-computed results.
module tb_ttc_readout_sequencer;

   logic clk = 1'b0;
   logic reset;
   int   cyc = 0;
   int   nChecks = 0;
   int   nFails = 0;

   ttc_readout_sequencer_if #(.NCHAN(5), .TMO_W(24)) bus ();

   ttc_readout_sequencer #(.NCHAN(5), .TMO_W(24)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.master)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Channel engine model: done pulse ten cycles after a start, unless silenced.
   logic [4:0]  modelDone = '0;
   logic [4:0]  injDone = '0;
   logic [21:0] modelBursts = '0;
   logic [21:0] chanBursts [5];
   logic [4:0]  chanSilent = '0;
   int          cd [5];

   assign bus.chan_rd_done   = modelDone | injDone;
   assign bus.chan_rd_bursts = modelBursts;

   always @(negedge clk) begin
      modelDone = '0;
      if (reset) begin
         for (int i = 0; i < 5; i++) cd[i] = 0;
      end else begin
         for (int i = 0; i < 5; i++) begin
            if (cd[i] > 0) begin
               cd[i] = cd[i] - 1;
               if (cd[i] == 0) begin
                  modelDone[i] = 1'b1;
                  modelBursts  = chanBursts[i];
               end
            end
         end
         for (int i = 0; i < 5; i++) begin
            if (bus.chan_rd_start[i] && !chanSilent[i]) cd[i] = 10;
         end
      end
   end

   // Event log sampled mid-cycle, after all stimulus for the cycle has settled.
   int          startCh[$];
   int          startCyc[$];
   int          doneCyc[$];
   int          readoutPulses = 0;
   int          collisions = 0;
   int          pops = 0;
   int          lastPopCyc = -1;
   int          lastHsCyc = -1;
   logic [21:0] lastSize = '0;

   always @(negedge clk) begin
      #2;
      if (!reset) begin
         for (int i = 0; i < 5; i++) begin
            if (bus.chan_rd_start[i]) begin
               startCh.push_back(i);
               startCyc.push_back(cyc);
            end
            if (modelDone[i]) doneCyc.push_back(cyc);
         end
         if (bus.readout_done) begin
            readoutPulses++;
            lastSize = bus.readout_size;
            if (bus.acq_trigger) collisions++;
         end
         if (bus.trig_fifo_valid && bus.trig_fifo_ready) begin
            pops++;
            lastPopCyc = cyc;
         end
         if (bus.hdr_valid && bus.hdr_ready) lastHsCyc = cyc;
      end
   end

   task automatic clearLogs();
      startCh.delete();
      startCyc.delete();
      doneCyc.delete();
      readoutPulses = 0;
      collisions = 0;
   endtask

   task automatic applyStimulus(input logic [127:0] w, input logic [4:0] en,
                                output int acceptCyc, output bit ok);
      bus.trig_fifo_data  = w;
      bus.chan_en         = en;
      bus.trig_fifo_valid = 1'b1;
      ok = 1'b0;
      acceptCyc = -1;
      for (int k = 0; k < 50; k++) begin
         if (bus.trig_fifo_ready) begin
            ok = 1'b1;
            acceptCyc = cyc;
            break;
         end
         @(negedge clk);
      end
      if (ok) @(negedge clk);
      bus.trig_fifo_valid = 1'b0;
      bus.chan_en = 5'b00000;
   endtask

   task automatic waitState(input logic [2:0] s, input int budget, output bit ok);
      ok = 1'b0;
      for (int k = 0; k < budget; k++) begin
         if (bus.state === s) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic releaseHeader();
      bus.hdr_ready = 1'b1;
      @(negedge clk);
      bus.hdr_ready = 1'b0;
   endtask

   task automatic applyReset();
      reset = 1'b1;
      bus.trig_fifo_valid = 1'b0;
      bus.trig_fifo_data  = '0;
      bus.chan_en         = '0;
      bus.timeout_limit   = '0;
      bus.acq_trigger     = 1'b0;
      bus.hdr_ready       = 1'b0;
      injDone = '0;
      chanSilent = '0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      clearLogs();
   endtask

   task automatic test_reset();
      applyReset();
      reset = 1'b1;
      repeat (2) @(negedge clk);
      nChecks++;
      if (bus.state !== 3'd0) begin nFails++; $display("[TB] FAIL reset_state: got %0d expected 0", bus.state); end
      nChecks++;
      if ({bus.trig_fifo_ready, bus.hdr_valid, bus.readout_done, bus.chan_rd_start} !== 8'd0) begin
         nFails++;
         $display("[TB] FAIL reset_strobes: got %b expected 0", {bus.trig_fifo_ready, bus.hdr_valid, bus.readout_done, bus.chan_rd_start});
      end
      nChecks++;
      if ({bus.error_timeout, bus.error_size_mismatch, bus.error_unexpected_done, bus.readout_size} !== 25'd0) begin
         nFails++;
         $display("[TB] FAIL reset_flags: got %b expected 0", {bus.error_timeout, bus.error_size_mismatch, bus.error_unexpected_done});
      end
      nChecks++;
      if (bus.hdr_data !== 128'd0) begin nFails++; $display("[TB] FAIL reset_hdr: got %h expected 0", bus.hdr_data); end
      reset = 1'b0;
      repeat (2) @(negedge clk);
      nChecks++;
      if (bus.trig_fifo_ready !== 1'b1) begin nFails++; $display("[TB] FAIL idle_ready: got %b expected 1", bus.trig_fifo_ready); end
   endtask

   task automatic test_three_channels();
      logic [127:0] w;
      int           acc;
      bit           ok;
      w = {33'd0, 1'b0, 2'b01, 24'h000011, 24'h000101, 44'h0ABCDEF0123};
      for (int i = 0; i < 5; i++) chanBursts[i] = 22'd1000;
      clearLogs();
      applyStimulus(w, 5'b10101, acc, ok);
      waitState(3'd4, 200, ok);
      nChecks++;
      if (!ok) begin nFails++; $display("[TB] FAIL seq_header_reached: got state %0d expected 4", bus.state); end
      nChecks++;
      if (startCh.size() !== 3 || startCh[0] !== 0 || startCh[1] !== 2 || startCh[2] !== 4) begin
         nFails++;
         $display("[TB] FAIL seq_order: got %0d starts expected ch0,ch2,ch4", startCh.size());
      end
      nChecks++;
      if (startCyc.size() !== 3 || doneCyc.size() !== 3 || startCyc[0] !== acc + 1 ||
          startCyc[1] !== doneCyc[0] + 1 || startCyc[2] !== doneCyc[1] + 1) begin
         nFails++;
         $display("[TB] FAIL seq_timing: got starts at %0d/%0d/%0d expected first at %0d, each one after a done",
                  startCyc.size() > 0 ? startCyc[0] : -1, startCyc.size() > 1 ? startCyc[1] : -1,
                  startCyc.size() > 2 ? startCyc[2] : -1, acc + 1);
      end
      nChecks++;
      if (readoutPulses !== 1 || lastSize !== 22'd1000) begin
         nFails++;
         $display("[TB] FAIL seq_readout: got %0d pulses size %0d expected 1 pulse size 1000", readoutPulses, lastSize);
      end
      nChecks++;
      if (bus.hdr_data[116:95] !== 22'd1000 || bus.hdr_data[94:0] !== w[94:0] || bus.hdr_data[127:117] !== 11'd0) begin
         nFails++;
         $display("[TB] FAIL seq_hdr: got %h expected size 1000 over word %h", bus.hdr_data, w[94:0]);
      end
      nChecks++;
      if ({bus.error_timeout, bus.error_size_mismatch, bus.error_unexpected_done} !== 3'b000) begin
         nFails++;
         $display("[TB] FAIL seq_flags: got %b expected 000", {bus.error_timeout, bus.error_size_mismatch, bus.error_unexpected_done});
      end
      releaseHeader();
      nChecks++;
      if (bus.state !== 3'd0) begin nFails++; $display("[TB] FAIL seq_back_idle: got %0d expected 0", bus.state); end
   endtask

   task automatic test_empty_word();
      logic [127:0] w;
      int           acc;
      bit           ok;
      w = {33'd0, 1'b1, 2'b10, 24'h000022, 24'h000202, 44'h01122334455};
      clearLogs();
      applyStimulus(w, 5'b11111, acc, ok);
      nChecks++;
      if (!ok || bus.hdr_valid !== 1'b1) begin
         nFails++;
         $display("[TB] FAIL empty_hdr_valid: got %b expected 1 one cycle after pop", bus.hdr_valid);
      end
      nChecks++;
      if (bus.hdr_data[116:95] !== 22'd0 || bus.hdr_data[94:0] !== w[94:0]) begin
         nFails++;
         $display("[TB] FAIL empty_hdr_data: got %h expected size 0 over word %h", bus.hdr_data, w[94:0]);
      end
      releaseHeader();
      repeat (3) @(negedge clk);
      nChecks++;
      if (startCh.size() !== 0 || readoutPulses !== 0) begin
         nFails++;
         $display("[TB] FAIL empty_no_readout: got %0d starts %0d pulses expected 0 and 0", startCh.size(), readoutPulses);
      end
   endtask

   task automatic test_acq_collision();
      logic [127:0] w;
      int           acc;
      bit           ok;
      bit           stayOk;
      int           pulsesHeld;
      w = {33'd0, 1'b0, 2'b00, 24'h000033, 24'h000303, 44'h00000000777};
      chanBursts[0] = 22'd77;
      clearLogs();
      applyStimulus(w, 5'b00001, acc, ok);
      waitState(3'd2, 20, ok);
      bus.acq_trigger = 1'b1;
      waitState(3'd3, 50, ok);
      stayOk = ok;
      for (int k = 0; k < 3; k++) begin
         if (bus.state !== 3'd3) stayOk = 1'b0;
         @(negedge clk);
      end
      pulsesHeld = readoutPulses;
      bus.acq_trigger = 1'b0;
      waitState(3'd4, 10, ok);
      nChecks++;
      if (!stayOk || pulsesHeld !== 0) begin
         nFails++;
         $display("[TB] FAIL acq_hold: got stay=%b pulses=%0d expected stay=1 pulses=0", stayOk, pulsesHeld);
      end
      nChecks++;
      if (!ok || readoutPulses !== 1 || lastSize !== 22'd77 || collisions !== 0) begin
         nFails++;
         $display("[TB] FAIL acq_release: got %0d pulses size %0d collisions %0d expected 1, 77, 0",
                  readoutPulses, lastSize, collisions);
      end
      releaseHeader();
   endtask

   task automatic test_back_to_back();
      logic [127:0] w3;
      logic [127:0] w4;
      logic [127:0] exp3;
      logic [127:0] exp4;
      int           acc;
      int           popsAtHdr;
      bit           ok;
      bit           stableOk;
      w3 = {33'd0, 1'b0, 2'b11, 24'h000044, 24'h000404, 44'h0FEDCBA9876};
      w4 = {33'd0, 1'b0, 2'b01, 24'h000045, 24'h000405, 44'h00000001234};
      exp3 = {11'd0, 22'd33, w3[94:0]};
      exp4 = {11'd0, 22'd33, w4[94:0]};
      chanBursts[0] = 22'd33;
      applyStimulus(w3, 5'b00001, acc, ok);
      bus.trig_fifo_data  = w4;
      bus.chan_en         = 5'b00001;
      bus.trig_fifo_valid = 1'b1;
      waitState(3'd4, 100, ok);
      popsAtHdr = pops;
      stableOk = ok;
      for (int k = 0; k < 20; k++) begin
         if (bus.hdr_data !== exp3 || bus.hdr_valid !== 1'b1 || bus.trig_fifo_ready !== 1'b0) stableOk = 1'b0;
         @(negedge clk);
      end
      nChecks++;
      if (!stableOk || pops !== popsAtHdr) begin
         nFails++;
         $display("[TB] FAIL stall_stable: got stable=%b pops=%0d expected stable=1 pops=%0d", stableOk, pops, popsAtHdr);
      end
      releaseHeader();
      @(negedge clk);
      bus.trig_fifo_valid = 1'b0;
      bus.chan_en = 5'b00000;
      nChecks++;
      if (lastPopCyc !== lastHsCyc + 1 || pops !== popsAtHdr + 1) begin
         nFails++;
         $display("[TB] FAIL stall_pop: got pop at %0d expected %0d", lastPopCyc, lastHsCyc + 1);
      end
      waitState(3'd4, 100, ok);
      nChecks++;
      if (!ok || bus.hdr_data !== exp4) begin
         nFails++;
         $display("[TB] FAIL second_hdr: got %h expected %h", bus.hdr_data, exp4);
      end
      releaseHeader();
   endtask

   task automatic test_timeout();
      logic [127:0] w;
      int           acc;
      bit           ok;
      w = {33'd0, 1'b0, 2'b00, 24'h000055, 24'h000505, 44'h00000005555};
      chanBursts[0] = 22'd10;
      chanBursts[1] = 22'd10;
      bus.timeout_limit = 24'd100;
      chanSilent = 5'b00010;
      clearLogs();
      applyStimulus(w, 5'b00011, acc, ok);
      waitState(3'd5, 400, ok);
      repeat (2) @(negedge clk);
      nChecks++;
      if (!ok || bus.state !== 3'd5 || bus.error_timeout !== 1'b1) begin
         nFails++;
         $display("[TB] FAIL timeout_error: got state %0d flag %b expected 5 and 1", bus.state, bus.error_timeout);
      end
      nChecks++;
      if (readoutPulses !== 0 || bus.hdr_valid !== 1'b0 || bus.trig_fifo_ready !== 1'b0) begin
         nFails++;
         $display("[TB] FAIL timeout_quiet: got %0d pulses hdr_valid %b ready %b expected 0 0 0",
                  readoutPulses, bus.hdr_valid, bus.trig_fifo_ready);
      end
      applyReset();
      nChecks++;
      if (bus.state !== 3'd0 || {bus.error_timeout, bus.error_size_mismatch, bus.error_unexpected_done} !== 3'b000) begin
         nFails++;
         $display("[TB] FAIL timeout_reset: got state %0d flags %b expected 0 and 000", bus.state,
                  {bus.error_timeout, bus.error_size_mismatch, bus.error_unexpected_done});
      end
   endtask

   task automatic test_size_mismatch();
      logic [127:0] w;
      int           acc;
      bit           ok;
      w = {33'd0, 1'b0, 2'b10, 24'h000066, 24'h000606, 44'h00000006666};
      chanBursts[0] = 22'd500;
      chanBursts[1] = 22'd400;
      clearLogs();
      applyStimulus(w, 5'b00011, acc, ok);
      waitState(3'd2, 20, ok);
      injDone = 5'b01000;
      @(negedge clk);
      injDone = 5'b00000;
      waitState(3'd4, 200, ok);
      nChecks++;
      if (!ok || bus.error_size_mismatch !== 1'b1 || bus.error_unexpected_done !== 1'b1) begin
         nFails++;
         $display("[TB] FAIL mismatch_flags: got mismatch %b unexpected %b expected 1 1",
                  bus.error_size_mismatch, bus.error_unexpected_done);
      end
      nChecks++;
      if (readoutPulses !== 1 || lastSize !== 22'd500 || bus.hdr_data[116:95] !== 22'd500) begin
         nFails++;
         $display("[TB] FAIL mismatch_size: got size %0d hdr size %0d expected 500", lastSize, bus.hdr_data[116:95]);
      end
      releaseHeader();
   endtask

   initial begin
      reset = 1'b1;
      bus.trig_fifo_valid = 1'b0;
      bus.trig_fifo_data  = '0;
      bus.chan_en         = '0;
      bus.timeout_limit   = '0;
      bus.acq_trigger     = 1'b0;
      bus.hdr_ready       = 1'b0;
      for (int i = 0; i < 5; i++) chanBursts[i] = '0;
      test_reset();
      test_three_channels();
      test_empty_word();
      test_acq_collision();
      test_back_to_back();
      test_timeout();
      test_size_mismatch();
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got no end of test, expected completion within time limit");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
